// File: rtl/m_cluster_mem_resp_if.sv
// Requester-side and backend-side signals of the cluster memory response unit.
// The unit itself uses the slave view; the requester/memory environment uses the master view.
interface m_cluster_mem_resp_if;
  logic         w_re;
  logic         w_we;
  logic [31:0]  w_addr;
  logic [2:0]   w_mem_ctrl;
  logic [31:0]  w_wdata;
  logic         w_busy;
  logic         w_done;
  logic         w_err;
  logic [127:0] w_rdata;
  logic [31:0]  w_rdata32;
  logic         o_mem_req;
  logic         o_mem_we;
  logic [27:0]  o_mem_addr;
  logic [127:0] o_mem_wdata;
  logic [15:0]  o_mem_wstrb;
  logic         i_mem_ack;
  logic [127:0] i_mem_rdata;

  modport slave (
    input  w_re, w_we, w_addr, w_mem_ctrl, w_wdata, i_mem_ack, i_mem_rdata,
    output w_busy, w_done, w_err, w_rdata, w_rdata32,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
  );

  modport master (
    output w_re, w_we, w_addr, w_mem_ctrl, w_wdata, i_mem_ack, i_mem_rdata,
    input  w_busy, w_done, w_err, w_rdata, w_rdata32,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb
  );
endinterface

// File: rtl/m_cluster_mem_resp.sv
// Turns a single byte/half/word load-store request into one 128-bit line access
// with alignment check, ack timeout and a one-cycle completion pulse.
//
// state | meaning
// IDLE  | waiting for w_re/w_we, request latched on acceptance
// CHECK | alignment check, misaligned access completes with error
// REQ   | backend request held until ack or timeout
// DONE  | w_done pulse, results held
module m_cluster_mem_resp #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic               CLK,
  input logic               RST,
  m_cluster_mem_resp_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHECK, REQ, DONE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [2:0]   ctrl_q, ctrl_d;
  logic [31:0]  wdata_q, wdata_d;
  logic         we_q, we_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         mem_req_q, mem_req_d;
  logic         mem_we_q, mem_we_d;
  logic [27:0]  mem_addr_q, mem_addr_d;
  logic [127:0] mem_wdata_q, mem_wdata_d;
  logic [15:0]  mem_wstrb_q, mem_wstrb_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [127:0] rdata_q, rdata_d;
  logic [1:0]   rsel_q, rsel_d;

  logic         busy;
  logic         req_in;
  logic         misaligned;
  logic [127:0] line_wdata;
  logic [15:0]  line_wstrb;

  assign req_in = bus.w_re | bus.w_we;

  // Store data is replicated across the line; the strobe selects the target lanes.
  always_comb begin
    line_wdata = '0;
    line_wstrb = '0;
    misaligned = 1'b0;
    case (ctrl_q)
      3'b000, 3'b100: begin
        line_wdata = {16{wdata_q[7:0]}};
        line_wstrb = 16'h0001 << addr_q[3:0];
      end
      3'b001, 3'b101: begin
        line_wdata = {8{wdata_q[15:0]}};
        line_wstrb = 16'h0003 << {addr_q[3:1], 1'b0};
        misaligned = addr_q[0];
      end
      default: begin
        line_wdata = {4{wdata_q}};
        line_wstrb = 16'h000F << {addr_q[3:2], 2'b00};
        misaligned = |addr_q[1:0];
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ctrl_d      = ctrl_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    done_d      = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    rsel_d      = rsel_q;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_in) begin
          busy    = 1'b1;
          state_d = CHECK;
          addr_d  = bus.w_addr;
          ctrl_d  = bus.w_mem_ctrl;
          wdata_d = bus.w_wdata;
          we_d    = bus.w_we;
        end
      end
      CHECK: begin
        busy = 1'b1;
        if (misaligned) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rsel_d  = addr_q[3:2];
        end else begin
          state_d     = REQ;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = addr_q[31:4];
          mem_wdata_d = we_q ? line_wdata : '0;
          mem_wstrb_d = we_q ? line_wstrb : '0;
        end
      end
      REQ: begin
        busy = 1'b1;
        // An ack in the final allowed cycle still completes successfully.
        if (bus.i_mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b0;
          rsel_d    = addr_q[3:2];
          if (!we_q) begin
            rdata_d = bus.i_mem_rdata;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '1;
          rsel_d    = addr_q[3:2];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      ctrl_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      rsel_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ctrl_q      <= ctrl_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      rsel_q      <= rsel_d;
    end
  end

  assign bus.w_busy      = busy;
  assign bus.w_done      = done_q;
  assign bus.w_err       = err_q;
  assign bus.w_rdata     = rdata_q;
  assign bus.w_rdata32   = rdata_q[{rsel_q, 5'd0} +: 32];
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_m_cluster_mem_resp.sv
// Scoreboard bench for m_cluster_mem_resp: driver pushes expected completions,
// a monitor pops them on w_done, a responder plays the backend memory.
`timescale 1ns/1ps
module tb_m_cluster_mem_resp;
  localparam int TO = 8;

  logic CLK;
  logic RST;
  m_cluster_mem_resp_if mif();

  m_cluster_mem_resp #(.TIMEOUT(TO)) dut (.CLK(CLK), .RST(RST), .bus(mif));

  typedef struct {
    logic         err;
    logic [127:0] line;
    logic [31:0]  word;
    int           lat;
    int           cyc0;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic         exp_access = 1'b0;
  logic         exp_we = 1'b0;
  logic [27:0]  exp_addr = '0;
  logic [127:0] exp_wdata = '0;
  logic [15:0]  exp_wstrb = '0;
  int           ack_delay = 0;
  logic [127:0] ack_line = '0;
  int           spur_rate = 1;
  logic [127:0] model_line = '0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sz_of(input logic [2:0] c);
    case (c)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [15:0] strb_of(input logic [31:0] a, input int sz);
    logic [15:0] s;
    int base;
    s = '0;
    base = (int'(a[3:0]) / sz) * sz;
    for (int i = 0; i < sz; i++) s[base + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [127:0] wdata_of(input logic [31:0] d, input int sz);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  // Backend memory: acks in the ack_delay-th REQ cycle, random spurious acks otherwise.
  initial begin
    int cnt;
    cnt = 0;
    mif.i_mem_ack   = 1'b0;
    mif.i_mem_rdata = '0;
    forever begin
      @(negedge CLK);
      if (mif.o_mem_req === 1'b1) begin
        cnt++;
        checks++;
        if (!exp_access) begin
          errors++;
          $display("FAIL mem_req_unexpected: got 1 expected 0 (t=%0t)", $time);
        end
        chk("mem_we", mif.o_mem_we, exp_we);
        chk("mem_addr", mif.o_mem_addr, exp_addr);
        chk("mem_wdata", mif.o_mem_wdata, exp_wdata);
        chk("mem_wstrb", mif.o_mem_wstrb, exp_wstrb);
        if (cnt == ack_delay) begin
          mif.i_mem_ack   = 1'b1;
          mif.i_mem_rdata = ack_line;
        end else begin
          mif.i_mem_ack   = 1'b0;
          mif.i_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        cnt = 0;
        if (spur_rate == 2 || (spur_rate == 1 && $urandom_range(3) == 0)) begin
          mif.i_mem_ack   = 1'b1;
          mif.i_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          mif.i_mem_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: compare each completion, and check results hold between completions.
  initial begin
    exp_t e;
    logic         m_err;
    logic [127:0] m_line;
    logic [31:0]  m_word;
    m_err  = 1'b0;
    m_line = '0;
    m_word = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        m_err  = 1'b0;
        m_line = '0;
        m_word = '0;
      end else if (mif.w_done === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got w_done=1 expected no completion (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          chk("done_err", mif.w_err, e.err);
          chk("done_rdata", mif.w_rdata, e.line);
          chk("done_rdata32", mif.w_rdata32, e.word);
          chk("done_latency", cyc - e.cyc0, e.lat);
          chk("done_busy", mif.w_busy, 0);
          m_err  = e.err;
          m_line = e.line;
          m_word = e.word;
        end
      end else begin
        chk("hold_err", mif.w_err, m_err);
        chk("hold_rdata", mif.w_rdata, m_line);
        chk("hold_rdata32", mif.w_rdata32, m_word);
      end
    end
  end

  task automatic do_txn(input logic we, input logic re, input logic [31:0] addr,
                        input logic [2:0] ctrl, input logic [31:0] wd,
                        input int d, input logic [127:0] line);
    exp_t e;
    int   sz;
    logic mis;
    logic acked;
    bit   seen;
    @(negedge CLK);
    chk("idle_busy", mif.w_busy, 0);
    sz    = sz_of(ctrl);
    mis   = (int'(addr[3:0]) % sz) != 0;
    acked = !mis && d >= 1 && d <= TO;
    exp_access = !mis;
    exp_we     = we;
    exp_addr   = addr[31:4];
    exp_wdata  = we ? wdata_of(wd, sz) : '0;
    exp_wstrb  = we ? strb_of(addr, sz) : '0;
    ack_delay  = d;
    ack_line   = line;
    if (!mis && !acked)      model_line = '1;
    else if (acked && !we)   model_line = line;
    e.err  = !acked;
    e.line = model_line;
    e.word = model_line[32*int'(addr[3:2]) +: 32];
    e.lat  = mis ? 2 : (acked ? 2 + d : 2 + TO);
    e.cyc0 = cyc;
    sbq.push_back(e);
    mif.w_we       = we;
    mif.w_re       = re;
    mif.w_addr     = addr;
    mif.w_mem_ctrl = ctrl;
    mif.w_wdata    = wd;
    #1;
    chk("req_busy", mif.w_busy, 1);
    @(negedge CLK);
    mif.w_we = 1'b0;
    mif.w_re = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mif.w_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no w_done expected one within 40 cycles");
    end
    repeat ($urandom_range(2)) @(negedge CLK);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ctrls [5];
    logic [31:0] a;
    logic        w;
    int          sz;
    bit          seen;
    ctrls[0] = 3'b000; ctrls[1] = 3'b001; ctrls[2] = 3'b010;
    ctrls[3] = 3'b100; ctrls[4] = 3'b101;
    mif.w_re = 1'b0; mif.w_we = 1'b0; mif.w_addr = '0;
    mif.w_mem_ctrl = '0; mif.w_wdata = '0;
    RST = 1'b0;
    #1 RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_busy", mif.w_busy, 0);
    chk("rst_done", mif.w_done, 0);
    chk("rst_err", mif.w_err, 0);
    chk("rst_rdata", mif.w_rdata, 0);
    chk("rst_rdata32", mif.w_rdata32, 0);
    chk("rst_mem_req", mif.o_mem_req, 0);
    chk("rst_mem_we", mif.o_mem_we, 0);
    chk("rst_mem_addr", mif.o_mem_addr, 0);
    chk("rst_mem_wdata", mif.o_mem_wdata, 0);
    chk("rst_mem_wstrb", mif.o_mem_wstrb, 0);
    RST = 1'b0;

    // Directed cases: aligned read, byte store, misaligned half, timeout, re+we word store.
    do_txn(1'b0, 1'b1, 32'h8000_0024, 3'b010, 32'h0, 2,
           128'h33333333_22222222_11111111_00000000);
    do_txn(1'b1, 1'b0, 32'h0000_0107, 3'b000, 32'h0000_00AB, 1, '0);
    do_txn(1'b1, 1'b0, 32'h0000_0103, 3'b001, 32'h0000_1234, 1, '0);
    do_txn(1'b0, 1'b1, 32'h0000_0040, 3'b010, 32'h0, 1000, '0);
    do_txn(1'b1, 1'b1, 32'h0000_0008, 3'b010, 32'hDEAD_BEEF, 1, '0);
    do_txn(1'b0, 1'b1, 32'h0000_0050, 3'b101, 32'h0, TO,
           {$urandom, $urandom, $urandom, $urandom});

    // Reset while the backend request is outstanding.
    @(negedge CLK);
    exp_access = 1'b1; exp_we = 1'b0; exp_addr = 28'h0000123;
    exp_wdata = '0; exp_wstrb = '0; ack_delay = 1000;
    mif.w_re = 1'b1; mif.w_addr = 32'h0000_1230; mif.w_mem_ctrl = 3'b010;
    @(negedge CLK);
    mif.w_re = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mif.o_mem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    chk("rst_test_req_seen", seen, 1);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_mem_req", mif.o_mem_req, 0);
    chk("mid_rst_busy", mif.w_busy, 0);
    chk("mid_rst_wstrb", mif.o_mem_wstrb, 0);
    chk("mid_rst_done", mif.w_done, 0);
    exp_access = 1'b0;
    spur_rate  = 2;
    model_line = '0;
    @(negedge CLK);
    #2 RST = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      chk("post_rst_done", mif.w_done, 0);
      chk("post_rst_mem_req", mif.o_mem_req, 0);
    end
    spur_rate = 1;

    for (int n = 0; n < 150; n++) begin
      w  = 1'($urandom_range(1));
      a  = $urandom;
      sz = sz_of(ctrls[$urandom_range(4)]);
      begin
        logic [2:0] c;
        c = ctrls[$urandom_range(4)];
        sz = sz_of(c);
        if ($urandom_range(1) == 1) a = a & ~32'(sz - 1);
        do_txn(w, w ? 1'($urandom_range(1)) : 1'b1, a, c, $urandom,
               $urandom_range(1, 10), {$urandom, $urandom, $urandom, $urandom});
      end
    end

    repeat (5) @(negedge CLK);
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
